// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: frame geometry defaults,
// controller states and the RGB565 -> RGB332 pixel reduction.
package cam_pkg;

  localparam int DEF_IMG_W  = 176;
  localparam int DEF_IMG_H  = 120;
  localparam int DEF_ADDR_W = 15;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_VS   = 3'd1,
    WAIT_LINE = 3'd2,
    BYTE_HI   = 3'd3,
    BYTE_LO   = 3'd4
  } cam_state_e;

  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] BLUE  = 8'h03;

  // hi = R4..R0 G5..G3, lo = G2..G0 B4..B0; keep the top bits of each channel
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchroniser for a bundle of camera signals, with rise/fall
// detection on the synchronised value.
module cam_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;
  logic [W-1:0] prev_r;

  // metastability stages plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
      prev_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign q    = sync_r;
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 capture sequencer: oversamples the camera bus in the system clock
// domain and writes RGB332 pixels into the frame buffer, one frame or continuously.
module ov7670_capture_ctrl
  import cam_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              CAM_PCLK,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_DATA,
  input  logic              START,
  input  logic              CONTINUOUS,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              LINE_ERR,
  output logic [7:0]        FRAME_CNT
);

  localparam logic [ADDR_W-1:0] W_LIM = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] H_LIM = ADDR_W'(IMG_H);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  logic [2:0] ctl_q_s, ctl_rise_s, ctl_fall_s;
  logic [7:0] data_q_s, data_rise_s, data_fall_s;
  logic       tick_s, vs_rise_s, vs_fall_s, href_rise_s, href_fall_s, href_s;
  logic       unused_s;

  cam_state_e state_r, state_nx_s;
  logic start_s, frame_start_s, line_start_s, hi_s, pix_s, line_end_s, frame_end_s;

  logic              cont_r, w_en_r, busy_r, frame_done_r, line_err_r;
  logic [7:0]        hi_r, w_data_r, frame_cnt_r;
  logic [ADDR_W-1:0] row_r, col_r, row_base_r, w_addr_r;

  // bit 0 PCLK, bit 1 VSYNC, bit 2 HREF; data goes through the same depth
  cam_sync #(.W(3)) u_sync_ctl (
    .clk(CLOCK), .rst_n(RESET_N), .d({CAM_HREF, CAM_VSYNC, CAM_PCLK}),
    .q(ctl_q_s), .rise(ctl_rise_s), .fall(ctl_fall_s)
  );

  cam_sync #(.W(8)) u_sync_data (
    .clk(CLOCK), .rst_n(RESET_N), .d(CAM_DATA),
    .q(data_q_s), .rise(data_rise_s), .fall(data_fall_s)
  );

  assign tick_s      = ctl_rise_s[0];
  assign vs_rise_s   = ctl_rise_s[1];
  assign vs_fall_s   = ctl_fall_s[1];
  assign href_rise_s = ctl_rise_s[2];
  assign href_fall_s = ctl_fall_s[2];
  assign href_s      = ctl_q_s[2];
  assign unused_s    = ^{ctl_q_s[1:0], ctl_fall_s[0], data_rise_s, data_fall_s};

  // state register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next state and one-cycle datapath commands; frame end outranks line end outranks bytes
  always_comb begin
    state_nx_s    = state_r;
    start_s       = 1'b0;
    frame_start_s = 1'b0;
    line_start_s  = 1'b0;
    hi_s          = 1'b0;
    pix_s         = 1'b0;
    line_end_s    = 1'b0;
    frame_end_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          start_s    = 1'b1;
          state_nx_s = WAIT_VS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT_VS: begin
        if (vs_fall_s) begin
          frame_start_s = 1'b1;
          state_nx_s    = WAIT_LINE;
        end else begin
          state_nx_s = WAIT_VS;
        end
      end
      WAIT_LINE: begin
        if (vs_rise_s) begin
          frame_end_s = 1'b1;
          state_nx_s  = cont_r ? WAIT_VS : IDLE;
        end else if (href_rise_s) begin
          line_start_s = 1'b1;
          state_nx_s   = BYTE_HI;
        end else begin
          state_nx_s = WAIT_LINE;
        end
      end
      BYTE_HI, BYTE_LO: begin
        if (vs_rise_s) begin
          frame_end_s = 1'b1;
          state_nx_s  = cont_r ? WAIT_VS : IDLE;
        end else if (href_fall_s) begin
          line_end_s = 1'b1;
          state_nx_s = WAIT_LINE;
        end else if (tick_s && href_s) begin
          if (state_r == BYTE_HI) begin
            hi_s       = 1'b1;
            state_nx_s = BYTE_LO;
          end else begin
            pix_s      = 1'b1;
            state_nx_s = BYTE_HI;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // counters, pixel assembly, write port and status
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cont_r       <= 1'b0;
      w_en_r       <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      line_err_r   <= 1'b0;
      hi_r         <= 8'd0;
      w_data_r     <= 8'd0;
      frame_cnt_r  <= 8'd0;
      row_r        <= {ADDR_W{1'b0}};
      col_r        <= {ADDR_W{1'b0}};
      row_base_r   <= {ADDR_W{1'b0}};
      w_addr_r     <= {ADDR_W{1'b0}};
    end else begin
      w_en_r       <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= (state_nx_s != IDLE);
      if (start_s) begin
        cont_r     <= CONTINUOUS;
        line_err_r <= 1'b0;
      end
      if (frame_start_s) begin
        row_r      <= {ADDR_W{1'b0}};
        row_base_r <= {ADDR_W{1'b0}};
      end
      if (line_start_s) begin
        col_r <= {ADDR_W{1'b0}};
      end
      if (hi_s) begin
        hi_r <= data_q_s;
      end
      if (pix_s) begin
        if ((col_r < W_LIM) && (row_r < H_LIM)) begin
          w_en_r   <= 1'b1;
          w_addr_r <= row_base_r + col_r;
          w_data_r <= rgb565_to_rgb332(hi_r, data_q_s);
        end else begin
          line_err_r <= 1'b1;
        end
        col_r <= (col_r < W_LIM) ? col_r + ONE : col_r;
      end
      if (line_end_s) begin
        if (state_r == BYTE_LO) begin
          line_err_r <= 1'b1;
        end
        if (row_r < H_LIM) begin
          row_r      <= row_r + ONE;
          row_base_r <= row_base_r + W_LIM;
        end
      end
      if (frame_end_s) begin
        frame_done_r <= 1'b1;
        frame_cnt_r  <= frame_cnt_r + 8'd1;
      end
    end
  end

  assign W_EN       = w_en_r;
  assign W_ADDR     = w_addr_r;
  assign W_DATA     = w_data_r;
  assign BUSY       = busy_r;
  assign FRAME_DONE = frame_done_r;
  assign LINE_ERR   = line_err_r;
  assign FRAME_CNT  = frame_cnt_r;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Bench for ov7670_capture_ctrl: drives a behavioural camera, predicts every
// frame-buffer write and frame completion, and a monitor scores DUT outputs.
module tb_ov7670_capture_ctrl;

  localparam int IW = 176;
  localparam int IH = 120;
  localparam int AW = 15;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          pclk = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0]    cdata = 8'd0;
  logic          start = 1'b0, cont = 1'b0;
  logic          W_EN, BUSY, FRAME_DONE, LINE_ERR;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA, FRAME_CNT;

  always #5 clk = ~clk;

  ov7670_capture_ctrl dut (
    .CLOCK(clk), .RESET_N(rst_n), .CAM_PCLK(pclk), .CAM_VSYNC(vsync),
    .CAM_HREF(href), .CAM_DATA(cdata), .START(start), .CONTINUOUS(cont),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE), .LINE_ERR(LINE_ERR), .FRAME_CNT(FRAME_CNT)
  );

  typedef struct { int addr; logic [7:0] data; } wr_t;
  wr_t exp_wr[$];
  int  exp_fd[$];
  wr_t mon_w;
  int  mon_fc;

  int n_checks = 0;
  int n_fail   = 0;
  int half     = 4;
  logic [7:0] lb [0:511];

  // reference model state: armed, continuous, capturing this frame, sticky error
  bit m_busy = 1'b0, m_cont = 1'b0, m_cap = 1'b0, m_err = 1'b0;
  int m_cnt = 0, m_row = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  // RGB565 split into channels, each reduced to its most significant bits
  function automatic logic [7:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo);
    int r, g, b;
    r = int'(hi) / 8;
    g = (int'(hi) % 8) * 8 + int'(lo) / 32;
    b = int'(lo) % 32;
    return 8'((r / 4) * 32 + (g / 8) * 4 + (b / 8));
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (W_EN === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write", W_ADDR, W_DATA);
        end else begin
          mon_w = exp_wr.pop_front();
          check("write_addr", 32'(W_ADDR), 32'(mon_w.addr));
          check("write_data", 32'(W_DATA), 32'(mon_w.data));
          check("write_in_frame", 32'(int'(W_ADDR) < IW * IH), 32'd1);
        end
      end
      if (FRAME_DONE === 1'b1) begin
        if (exp_fd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_done: got FRAME_CNT %0d, required no pulse", FRAME_CNT);
        end else begin
          mon_fc = exp_fd.pop_front();
          check("frame_done_cnt", 32'(FRAME_CNT), 32'(mon_fc));
        end
      end
    end
  end

  task automatic pclk_tick(input logic [7:0] d, input logic h, input logic v);
    pclk = 1'b0; cdata = d; href = h; vsync = v;
    repeat (half) @(negedge clk);
    pclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic do_start(input logic c);
    @(negedge clk);
    start = 1'b1; cont = c;
    if (!m_busy) begin
      m_busy = 1'b1; m_cont = c; m_err = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic frame_begin();
    repeat (3) pclk_tick(8'h00, 1'b0, 1'b1);
    m_cap = m_busy;
    m_row = 0;
    repeat (3) pclk_tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) lb[i] = 8'($urandom);
  endtask

  // abort=1 leaves HREF high so the following frame_end cuts the line
  task automatic send_line(input int nb, input bit abort);
    wr_t w;
    if (m_cap) begin
      for (int p = 0; p < nb / 2; p++) begin
        if (m_row < IH && p < IW) begin
          w.addr = m_row * IW + p;
          w.data = exp_pix(lb[2*p], lb[2*p+1]);
          exp_wr.push_back(w);
        end else begin
          m_err = 1'b1;
        end
      end
      if (!abort && (nb % 2) == 1) m_err = 1'b1;
      m_row++;
    end
    for (int i = 0; i < nb; i++) pclk_tick(lb[i], 1'b1, 1'b0);
    if (!abort) repeat (2) pclk_tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame_end(input logic h);
    if (m_cap) begin
      m_cnt = (m_cnt + 1) % 256;
      exp_fd.push_back(m_cnt);
      if (!m_cont) m_busy = 1'b0;
      m_cap = 1'b0;
    end
    repeat (3) pclk_tick(8'($urandom), h, 1'b1);
    if (h) pclk_tick(8'h00, 1'b0, 1'b1);
  endtask

  task automatic drain_and_check(input string tag);
    repeat (20) @(negedge clk);
    check({tag, "_pending_writes"}, 32'(exp_wr.size()), 32'd0);
    check({tag, "_pending_frame_done"}, 32'(exp_fd.size()), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'(m_busy));
    check({tag, "_line_err"}, 32'(LINE_ERR), 32'(m_err));
    check({tag, "_frame_cnt"}, 32'(FRAME_CNT), 32'(m_cnt));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_w_en"}, 32'(W_EN), 32'd0);
    check({tag, "_w_addr"}, 32'(W_ADDR), 32'd0);
    check({tag, "_w_data"}, 32'(W_DATA), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_frame_done"}, 32'(FRAME_DONE), 32'd0);
    check({tag, "_line_err"}, 32'(LINE_ERR), 32'd0);
    check({tag, "_frame_cnt"}, 32'(FRAME_CNT), 32'd0);
  endtask

  initial begin
    int nl, nb;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single-shot: two lines of four red pixels
    do_start(1'b0);
    repeat (2) @(negedge clk);
    check("busy_after_start", 32'(BUSY), 32'd1);
    frame_begin();
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 8; i++) lb[i] = (i % 2 == 0) ? 8'hE0 : 8'h00;
      send_line(8, 1'b0);
    end
    frame_end(1'b0);
    drain_and_check("single");

    // packing corner cases followed by random pixels
    do_start(1'b0);
    frame_begin();
    fill_rand(12);
    lb[0] = 8'h07; lb[1] = 8'hE0; lb[2] = 8'h00; lb[3] = 8'h1F;
    send_line(12, 1'b0);
    fill_rand(10);
    send_line(10, 1'b0);
    frame_end(1'b0);
    drain_and_check("packing");

    for (int f = 0; f < 3; f++) begin
      do_start(1'b0);
      frame_begin();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        nb = 2 * $urandom_range(1, 6);
        fill_rand(nb);
        send_line(nb, 1'b0);
      end
      frame_end(1'b0);
      drain_and_check("random");
    end

    // odd byte count, then a fresh line to show the stray byte was dropped
    do_start(1'b0);
    frame_begin();
    fill_rand(7);
    send_line(7, 1'b0);
    fill_rand(4);
    send_line(4, 1'b0);
    frame_end(1'b0);
    drain_and_check("odd");

    // VSYNC rising in the middle of a line
    do_start(1'b0);
    frame_begin();
    fill_rand(4);
    send_line(4, 1'b0);
    fill_rand(5);
    send_line(5, 1'b1);
    frame_end(1'b1);
    drain_and_check("abort");

    // overflow: wide lines and more rows than the buffer holds
    half = 2;
    do_start(1'b0);
    frame_begin();
    for (int r = 0; r < 122; r++) begin
      nb = (r == 0 || r == 119) ? 360 : ((r >= 120) ? 6 : 2);
      fill_rand(nb);
      send_line(nb, 1'b0);
    end
    frame_end(1'b0);
    drain_and_check("overflow");
    half = 4;

    // continuous: three frames, a START mid-frame must be ignored
    do_start(1'b1);
    for (int f = 0; f < 3; f++) begin
      frame_begin();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        nb = 2 * $urandom_range(1, 5);
        fill_rand(nb);
        send_line(nb, 1'b0);
        if (f == 1 && l == 0) do_start(1'b0);
      end
      frame_end(1'b0);
    end
    drain_and_check("continuous");

    // reset in the middle of a line
    frame_begin();
    fill_rand(4);
    send_line(4, 1'b0);
    pclk_tick(8'hAA, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_busy = 1'b0; m_cont = 1'b0; m_cap = 1'b0; m_err = 1'b0; m_cnt = 0;
    exp_wr.delete();
    exp_fd.delete();
    repeat (3) @(negedge clk);
    check_zero("midreset");
    rst_n = 1'b1;
    do_start(1'b0);
    for (int i = 0; i < 6; i++) pclk_tick(8'($urandom), 1'b1, 1'b0);
    repeat (2) pclk_tick(8'h00, 1'b0, 1'b0);
    frame_end(1'b0);
    frame_begin();
    fill_rand(8);
    send_line(8, 1'b0);
    frame_end(1'b0);
    drain_and_check("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_ctrl.md
Name: ov7670_capture_ctrl

Overview:
- Sequences OV7670 pixel capture into the dual-port M9K frame buffer, replacing free-running write-address logic clocked directly on PCLK.
- Resynchronises camera PCLK/VSYNC/HREF/DATA into one system clock domain, aligns to frame and line boundaries, and packs RGB565 byte pairs into RGB332.
- Generates bounded frame-buffer write strobes, addresses and data, and supports single-shot or continuous capture with status reporting to the VGA/processing side.

Parameters:
- IMG_W, 176, pixels stored per line.
- IMG_H, 120, lines stored per frame.
- ADDR_W, 15, frame-buffer address width; IMG_W*IMG_H must be at most 2**ADDR_W.

Ports:
- CLOCK  in  1  system clock (CLK_50_PLL); must be at least 4x camera PCLK.
- RESET_N  in  1  asynchronous active-low reset.
- CAM_PCLK  in  1  camera pixel clock, asynchronous, sampled as data.
- CAM_VSYNC  in  1  camera vertical sync; high = vertical blanking.
- CAM_HREF  in  1  camera line valid; high = pixel bytes present.
- CAM_DATA  in  8  camera data bus.
- START  in  1  one-cycle pulse that arms capture.
- CONTINUOUS  in  1  1 = re-arm automatically after each frame; sampled at START.
- W_EN  out  1  frame-buffer write strobe, one cycle per pixel.
- W_ADDR  out  ADDR_W  frame-buffer write address.
- W_DATA  out  8  RGB332 pixel.
- BUSY  out  1  high in any state other than IDLE.
- FRAME_DONE  out  1  one-cycle pulse at the end of each captured frame.
- LINE_ERR  out  1  sticky flag: odd byte count or overflow seen.
- FRAME_CNT  out  8  count of completed frames.

Behaviour:
- Reset values: all outputs 0, all counters 0, state IDLE.
- Synchronisation:
  - 2-FF synchronisers on CAM_PCLK, CAM_VSYNC and CAM_HREF.
  - CAM_DATA is registered through the same depth, so data and PCLK stay aligned.
  - A PCLK rising edge is detected on the synchronised signal; this event is the "tick". Every camera sample is taken on a tick only.
  - VSYNC rise/fall and HREF rise/fall are edge-detected from the synchronised signals.
- States:
  - IDLE: on START, latch CONTINUOUS, clear LINE_ERR, go to WAIT_VS.
  - WAIT_VS: wait for a VSYNC falling edge, i.e. the start of a full frame. Then clear row = 0 and row_base = 0 and go to WAIT_LINE.
  - WAIT_LINE: on HREF rising, set col = 0 and go to BYTE_HI.
  - BYTE_HI: on a tick with HREF high, latch the high byte and go to BYTE_LO.
  - BYTE_LO: on a tick with HREF high, form the pixel and go to BYTE_HI.
  - Line end, HREF falling in BYTE_HI or BYTE_LO:
    - If in BYTE_LO (odd byte count), drop the pending high byte and set LINE_ERR.
    - row increments, saturating at IMG_H. row_base += IMG_W, only while row < IMG_H.
    - Go to WAIT_LINE.
  - Frame end, VSYNC rising in WAIT_LINE, BYTE_HI or BYTE_LO:
    - This aborts any partial line; no write is issued for a dangling high byte.
    - Pulse FRAME_DONE and FRAME_CNT++ (wraps 255 to 0).
    - Go to WAIT_VS if continuous, else IDLE.
  - VSYNC rising in WAIT_VS has no effect.
- Pixel packing: hi = R4..R0 G5..G3, lo = G2..G0 B4..B0. W_DATA = {hi[7:5], hi[2:0], lo[4:3]}.
- Writes:
  - W_EN pulses exactly one cycle, in the cycle after the BYTE_LO tick.
  - W_ADDR = row_base + col, held in a register (no multiplier). col increments after each write.
  - Write is suppressed when col >= IMG_W or row >= IMG_H. Suppression of an overflow sets LINE_ERR; col keeps counting, saturating.
  - Short lines leave the remaining addresses unwritten; the next line still starts at row_base + IMG_W.
- W_ADDR and W_DATA hold their last values between strobes.
- START while BUSY is ignored. A reset mid-frame returns to IDLE immediately with no further strobes.
- Latency: camera low-byte PCLK edge to W_EN is 3 to 4 CLOCK cycles.

Decomposition:
- Package cam_pkg:
  - IMG_W / IMG_H defaults.
  - State enum: IDLE, WAIT_VS, WAIT_LINE, BYTE_HI, BYTE_LO.
  - RGB332 colour constants RED, GREEN, BLUE.
  - rgb565_to_rgb332 function.
- Sub-module cam_sync: parameterised-width 2-FF synchroniser plus rise/fall edge detect, instantiated for the PCLK/VSYNC/HREF control signals and the data bus.

Test Plan:
- Single-shot frame: START, CONTINUOUS=0; 2 lines of 4 pixels, hi=0xE0, lo=0x00 -> W_ADDR 0..3 and 176..179, W_DATA=0xE0, one FRAME_DONE, FRAME_CNT=1, BUSY falls, then IDLE.
- Packing: hi=0x07, lo=0xE0 -> W_DATA=0x1C. hi=0x00, lo=0x1F -> W_DATA=0x03.
- Overflow: line of 180 pixels, 122 lines -> writes only to addresses 0..21119, no address >= 21120, LINE_ERR=1.
- Odd bytes / abort: line of 7 bytes -> 3 writes, LINE_ERR=1. VSYNC rising mid-line -> FRAME_DONE, no extra W_EN.
- Continuous mode: 3 frames -> FRAME_CNT=3 and addresses restart at 0 each frame. START mid-frame -> ignored.
- Reset mid-line, then START -> outputs 0; capture resumes only after the next VSYNC fall.
